// File: rtl/analyzer_capture_pkg.sv
// Shared types and helpers for the logic-analyzer capture block.
package analyzer_capture_pkg;

   // Capture controller states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } cap_state_e;

   // Address width for a buffer of the given depth (never narrower than 1 bit).
   function automatic int calc_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/analyzer_capture_sync.sv
// Multi-bit flop-chain synchroniser: q is d delayed by SYNC clock edges.
module sync_chain #(
   parameter int CH   = 1,
   parameter int SYNC = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CH-1:0] d,
   output logic [CH-1:0] q
);

   logic [CH-1:0] stage_q [SYNC];

   // Shift the raw inputs through SYNC flop stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < SYNC; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q = stage_q[SYNC-1];

endmodule

// File: rtl/analyzer_capture.sv
// Multi-channel logic-analyzer capture: synchronise probes, record into a
// circular buffer, freeze after a mask/value trigger plus post-trigger count,
// then stream the captured samples out oldest-first over valid/ready.
module analyzer_capture
   import analyzer_capture_pkg::*;
#(
   parameter  int CH    = 5,
   parameter  int SYNC  = 2,
   parameter  int DEPTH = 16,
   localparam int AW    = calc_aw(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CH-1:0] ch_in,
   output logic [CH-1:0] ch_sync,
   input  logic          arm,
   input  logic          abort,
   input  logic [CH-1:0] trig_mask,
   input  logic [CH-1:0] trig_value,
   input  logic          trig_edge,
   input  logic [AW-1:0] post_count,
   output logic          armed,
   output logic          triggered,
   output logic          done,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [CH-1:0] rd_data,
   output logic          rd_last
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   cap_state_e    state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   fill_q, fill_d;
   logic [AW-1:0] remain_q, remain_d;
   logic [AW:0]   rd_idx_q, rd_idx_d;
   logic          match_d_q;
   logic          wr_en;
   logic          match, trig, xfer;
   logic [AW-1:0] rd_base, rd_ptr;
   logic [CH-1:0] mem_q [DEPTH];

   sync_chain #(.CH(CH), .SYNC(SYNC)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ch_in),
      .q     (ch_sync)
   );

   assign match = (((ch_sync ^ trig_value) & trig_mask) == '0);
   assign trig  = trig_edge ? (match & ~match_d_q) : match;

   // Readout walks forward from the oldest retained sample; once the buffer
   // has wrapped, the oldest sample sits at the next write position.
   assign rd_base  = (fill_q == FULL) ? wr_ptr_q : '0;
   assign rd_ptr   = rd_base + rd_idx_q[AW-1:0];
   assign rd_valid = (state_q == ST_DONE) && (rd_idx_q < fill_q);
   assign rd_last  = rd_valid && (rd_idx_q == fill_q - 1'b1);
   assign rd_data  = rd_valid ? mem_q[rd_ptr] : '0;
   assign xfer     = rd_valid & rd_ready;

   assign armed     = (state_q == ST_ARMED);
   assign triggered = (state_q == ST_POST) || (state_q == ST_DONE);
   assign done      = (state_q == ST_DONE);

   // Next-state, write enable and pointer/counter updates.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      remain_d = remain_q;
      rd_idx_d = rd_idx_q;
      wr_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               state_d  = ST_ARMED;
               wr_ptr_d = '0;
               fill_d   = '0;
               rd_idx_d = '0;
            end
         end
         ST_ARMED: begin
            wr_en = 1'b1;
            if (trig) begin
               remain_d = post_count;
               state_d  = (post_count == '0) ? ST_DONE : ST_POST;
            end
         end
         ST_POST: begin
            wr_en    = 1'b1;
            remain_d = remain_q - 1'b1;
            if (remain_q == AW'(1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (arm) begin
               state_d  = ST_ARMED;
               wr_ptr_d = '0;
               fill_d   = '0;
               rd_idx_d = '0;
            end else if (xfer) begin
               rd_idx_d = rd_idx_q + 1'b1;
               if (rd_last) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort) begin
         state_d  = ST_IDLE;
         wr_en    = 1'b0;
         rd_idx_d = rd_idx_q;
      end
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         fill_d   = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
      end
   end

   // Control registers. match_d tracks match continuously so that a pattern
   // already present when the capture is armed does not count as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         fill_q    <= '0;
         remain_q  <= '0;
         rd_idx_q  <= '0;
         match_d_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         fill_q    <= fill_d;
         remain_q  <= remain_d;
         rd_idx_q  <= rd_idx_d;
         match_d_q <= match;
      end
   end

   // Capture buffer; contents are deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= ch_sync;
   end

endmodule
